// File: rtl/double_to_long.sv
// IEEE-754 double to signed 64-bit integer converter (truncation toward zero).
// Serial design: one operand in flight, mantissa aligned one bit per cycle.
module double_to_long (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic [2:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising clk edge where both the
  // strobe (valid) and the ack (ready) are high; a strobe, once raised,
  // holds its data stable until that edge.

  typedef enum logic [2:0] {
    GET_A         = 3'd0,
    UNPACK        = 3'd1,
    SPECIAL_CASES = 3'd2,
    CONVERT       = 3'd3,
    NEGATE        = 3'd4,
    PUT_Z         = 3'd5
  } state_t;

  state_t             state;
  logic [63:0]        a;
  logic [63:0]        m;
  logic [63:0]        z;
  logic signed [12:0] e;
  logic               s;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= 64'd0;
      a            <= 64'd0;
      m            <= 64'd0;
      z            <= 64'd0;
      e            <= 13'sd0;
      s            <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= UNPACK;
          end
        end
        UNPACK: begin
          m     <= {1'b1, a[51:0], 11'd0};
          e     <= $signed({2'b00, a[62:52]}) - 13'sd1023;
          s     <= a[63];
          state <= SPECIAL_CASES;
        end
        SPECIAL_CASES: begin
          // Exponent field 2047 shows up here as e == 1024.
          if (e == 13'sd1024) begin
            z     <= 64'h8000_0000_0000_0000;
            state <= PUT_Z;
          end else if (e > 13'sd62) begin
            z     <= 64'h8000_0000_0000_0000;
            state <= PUT_Z;
          end else if (e < 13'sd0) begin
            z     <= 64'd0;
            state <= PUT_Z;
          end else begin
            state <= CONVERT;
          end
        end
        CONVERT: begin
          if (e < 13'sd63) begin
            m <= m >> 1;
            e <= e + 13'sd1;
          end else begin
            state <= NEGATE;
          end
        end
        NEGATE: begin
          z     <= s ? -m : m;
          state <= PUT_Z;
        end
        PUT_Z: begin
          if (!output_z_stb) begin
            output_z     <= z;
            output_z_stb <= 1'b1;
          end else if (output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: doc/double_to_long.md
DOUBLE_TO_LONG -- requirements
Module: double_to_long

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port input_a, input, 64: IEEE-754 double operand.
REQ-004 SHALL have port input_a_stb, input, 1: operand valid.
REQ-005 SHALL have port input_a_ack, output, 1: operand accepted.
REQ-006 SHALL have port output_z, output, 64: two's-complement signed 64-bit integer result.
REQ-007 SHALL have port output_z_stb, output, 1: result valid.
REQ-008 SHALL have port output_z_ack, input, 1: result consumed.

Function
REQ-009 SHALL convert a double to a signed 64-bit integer, truncating toward zero.
REQ-010 SHALL use states get_a, unpack, special_cases, convert, negate, put_z, in that order; special_cases may jump directly to put_z.
REQ-011 get_a: SHALL drive input_a_ack high from the cycle after entry; operand captured and ack dropped on the edge where ack && input_a_stb; next state unpack.
REQ-012 unpack (1 cycle): SHALL form m = {1'b1, a[51:0], 11'd0} (64 bits), e = a[62:52] - 1023 (13-bit signed), s = a[63].
REQ-013 special_cases (1 cycle), with priority: exponent field 2047 (NaN or Inf) -> z = 0x8000000000000000, put_z.
REQ-014 special_cases, next priority: e > 62 -> z = 0x8000000000000000 (saturate; covers exact -2^63), put_z.
REQ-015 special_cases, next priority: e < 0 (includes ±0 and denormals) -> z = 0, put_z.
REQ-016 special_cases, otherwise: next state convert.
REQ-017 convert: while e < 63, SHALL shift m right by 1 and increment e, one step per cycle; on the cycle e == 63, next state negate.
REQ-018 negate (1 cycle): z = s ? -m : m (64-bit two's complement); next state put_z.
REQ-019 put_z: SHALL load output_z with z and assert output_z_stb from the cycle after entry; hold both stable until output_z_stb && output_z_ack at an edge, then drop stb and return to get_a.
REQ-020 Latency, normal path: output_z_stb SHALL rise 68-e edges after the capture edge (e = 0 -> 68, e = 62 -> 6).
REQ-021 Latency, special path: output_z_stb SHALL rise 3 edges after the capture edge.
REQ-022 input_a_ack SHALL be low in all states except get_a; only one operand is in flight at a time.
REQ-023 output_z_ack while output_z_stb is low SHALL be ignored.
REQ-024 input_a_stb outside get_a SHALL be ignored and SHALL NOT be acknowledged.
REQ-025 A held output_z_ack SHALL complete exactly one transfer per result.

Reset
REQ-026 rst low SHALL immediately force state get_a, input_a_ack 0, output_z_stb 0, output_z 0, regardless of clock.
REQ-027 Reset mid-operation SHALL abandon the in-flight operand with no result produced.
REQ-028 After rst deasserts, input_a_ack SHALL rise on the first clock edge after deassertion.

Verification
REQ-029 0x3FF0000000000000 (1.0) -> 0x0000000000000001, stb at edge 68.
REQ-030 0xC004000000000000 (-2.5) -> 0xFFFFFFFFFFFFFFFE; 0x3FE0000000000000 (0.5) -> 0x0, stb at edge 3.
REQ-031 0x43D0000000000000 (2^62) -> 0x4000000000000000, stb at edge 6; 0x43E0000000000000 (2^63) -> 0x8000000000000000.
REQ-032 0x7FF8000000000000 (NaN) and 0xFFF0000000000000 (-Inf) -> 0x8000000000000000; 0x8000000000000000 (-0) -> 0x0.
REQ-033 Backpressure: hold output_z_ack low 10 cycles after stb rises -> output_z and stb stable throughout; a single ack pulse -> stb falls, input_a_ack rises next cycle.
REQ-034 Pull rst low during convert -> acks and stb low at once; output_z = 0; after release, next operand converts correctly.
